text_frame_ram: RTL and testbench
=================================

Name: text_frame_ram

Overview:
- Parametrised character frame buffer holding a ROWS x COLS grid of DATA_WIDTH-bit codes.
- An internal write cursor places incoming characters and interprets CR, LF and backspace as cursor commands rather than storing them.
- It has a registered random-access read port, NUM_TAPS registered live taps of row 0, and a hardware clear sweep that runs after reset or on request.
- It sits between the byte receive path and the display/compare logic.

Parameters:
- DATA_WIDTH, 8, width of each stored code.
- ROWS, 4, grid rows; must be >= 2.
- COLS, 32, grid columns; must be >= 2.
- NUM_TAPS, 2, number of continuously read cells, row 0 cols 0..NUM_TAPS-1; 1 <= NUM_TAPS <= COLS.
- WRAP_MODE, 1, 1 = cursor wraps from last cell to (0,0); 0 = block enters FULL and drops printable writes.
- CR_CODE, 8'h0D, carriage-return code.
- LF_CODE, 8'h0A, line-feed code.
- BS_CODE, 8'h08, backspace code.
- FILL_CODE, 8'h00, value written by clear and by backspace.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous single-cycle request to start a clear sweep.
- we  in  1  write strobe for din.
- din  in  DATA_WIDTH  character or command code.
- re  in  1  read request.
- r_row  in  $clog2(ROWS)  read row address.
- r_col  in  $clog2(COLS)  read column address.
- dout  out  DATA_WIDTH  read data.
- dout_valid  out  1  dout is valid this cycle.
- taps  out  NUM_TAPS*DATA_WIDTH  row 0 cells; cell k is at bits [k*DATA_WIDTH +: DATA_WIDTH].
- cur_row  out  $clog2(ROWS)  cursor row.
- cur_col  out  $clog2(COLS)  cursor column.
- busy  out  1  clear sweep in progress.
- full  out  1  FULL state (WRAP_MODE=0 only).

Behaviour:
- Reset (reset=0, asynchronous):
  - Cursor goes to (0,0); dout, dout_valid, taps and full go to 0.
  - The FSM goes to CLEAR with the sweep counter at 0, so busy=1.
  - Memory is not reset directly; the sweep clears it.
- FSM states are CLEAR, RUN and FULL.
- CLEAR:
  - Writes FILL_CODE to one cell per cycle in row-major order, starting at (0,0).
  - Takes exactly ROWS*COLS cycles, then goes to RUN with cursor (0,0).
  - we is ignored and the data is dropped.
  - clear during CLEAR restarts the sweep at (0,0).
- RUN, with we=1:
  - din is not CR_CODE, LF_CODE or BS_CODE: write din to [cur_row][cur_col], then advance the cursor.
    - col+1; if col=COLS-1, go to col 0 and row+1.
    - After the last cell (ROWS-1,COLS-1): WRAP_MODE=1 gives (0,0); WRAP_MODE=0 gives FULL with the cursor held at the last cell.
  - CR_CODE: col <= 0, row unchanged, no memory write.
  - LF_CODE: row <= row+1, col <= 0, no memory write. On the last row: WRAP_MODE=1 gives row 0; WRAP_MODE=0 gives FULL.
  - BS_CODE with col>0: col <= col-1 and FILL_CODE is written to the new position. With col=0: no-op, with no row retreat.
- FULL:
  - full=1.
  - Printable codes and LF are dropped.
  - CR moves col to 0 and returns to RUN.
  - BS behaves as in RUN, using the held cursor position, and returns to RUN.
- clear=1 in any state:
  - Enters CLEAR next cycle and takes priority over a simultaneous we, whose data is dropped.
  - Cursor is reset to (0,0) and full is cleared.
- Read port:
  - re sampled at cycle N gives dout = mem[r_row][r_col] and dout_valid=1 in cycle N+1.
  - dout_valid is 0 in cycles following re=0; dout holds its last value.
  - Out-of-range address (r_row>=ROWS or r_col>=COLS) returns FILL_CODE with dout_valid=1.
  - Read and write to the same cell in the same cycle returns the old data.
  - Reads are permitted during CLEAR and return the current array contents.
- Taps: registered every cycle from row 0, cols 0..NUM_TAPS-1, with 1-cycle latency. Same old-data rule as the read port.
- Cursor outputs are registers and reflect the post-update position the cycle after the write.

Test Plan:
- Release reset and count cycles -> busy=1 for exactly ROWS*COLS=128 cycles; then busy=0, cursor (0,0), and reading all 128 cells gives 8'h00 each.
- Write 'A'(41),'B'(42), then CR, then 'C'(43) -> mem[0][0]=43, mem[0][1]=42; taps={42,43} one cycle after the last write; cursor (0,1).
- Write 'X', LF, 'Y' -> mem[0][0]=58 and mem[1][0]=59; 8'h0A is never stored; cursor (1,1).
- WRAP_MODE=0, write 128 printable bytes, then 'Z' -> full=1 after byte 128; 'Z' dropped; mem[3][31] keeps byte 128.
- Same FULL setup, then CR -> full=0, cursor (3,0).
- Cursor (2,5), send BS -> cursor (2,4) and mem[2][4]=00. BS at (2,0) -> no change.
- Assert clear and we together mid-stream -> write dropped; busy=1 for 128 cycles. Pulse reset low mid-sweep -> sweep restarts, with busy high for a full 128 cycles after release.
- Read (0,0) with re in the same cycle as a write of 55 there -> old value returned, then 55 on the next read. Read r_row=3, r_col=31 with ROWS=3 -> 00, dout_valid=1.

Source files
------------

// File: rtl/text_frame_ram_if.sv
// Bus bundle for text_frame_ram: writer/reader controls in, read data, taps and status out.
// The master side drives writes, clear and reads; the slave side is the frame buffer itself.
interface text_frame_ram_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLS       = 32,
    parameter int unsigned NUM_TAPS   = 2
);
    localparam int unsigned ROW_W = $clog2(ROWS);
    localparam int unsigned COL_W = $clog2(COLS);

    logic                           clear;
    logic                           we;
    logic [DATA_WIDTH-1:0]          din;
    logic                           re;
    logic [ROW_W-1:0]               r_row;
    logic [COL_W-1:0]               r_col;
    logic [DATA_WIDTH-1:0]          dout;
    logic                           dout_valid;
    logic [NUM_TAPS*DATA_WIDTH-1:0] taps;
    logic [ROW_W-1:0]               cur_row;
    logic [COL_W-1:0]               cur_col;
    logic                           busy;
    logic                           full;

    modport master (
        output clear, we, din, re, r_row, r_col,
        input  dout, dout_valid, taps, cur_row, cur_col, busy, full
    );

    modport slave (
        input  clear, we, din, re, r_row, r_col,
        output dout, dout_valid, taps, cur_row, cur_col, busy, full
    );
endinterface

// File: rtl/text_frame_ram.sv
// Character frame buffer: cursor-driven writes with CR/LF/BS commands, registered read port,
// registered row-0 taps and a one-cell-per-cycle clear sweep after reset or on request.
module text_frame_ram #(
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           ROWS       = 4,
    parameter int unsigned           COLS       = 32,
    parameter int unsigned           NUM_TAPS   = 2,
    parameter bit                    WRAP_MODE  = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CR_CODE    = 'h0D,
    parameter logic [DATA_WIDTH-1:0] LF_CODE    = 'h0A,
    parameter logic [DATA_WIDTH-1:0] BS_CODE    = 'h08,
    parameter logic [DATA_WIDTH-1:0] FILL_CODE  = 'h00
) (
    input logic              clk,
    input logic              reset,
    text_frame_ram_if.slave  bus
);
    localparam int unsigned ROW_W = $clog2(ROWS);
    localparam int unsigned COL_W = $clog2(COLS);

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);

    logic [DATA_WIDTH-1:0] mem [ROWS][COLS];

    logic [1:0]       state_q, state_d;
    logic [ROW_W-1:0] cur_row_q, cur_row_d;
    logic [COL_W-1:0] cur_col_q, cur_col_d;
    logic [ROW_W-1:0] swp_row_q, swp_row_d;
    logic [COL_W-1:0] swp_col_q, swp_col_d;

    logic                  wr_en;
    logic [ROW_W-1:0]      wr_row;
    logic [COL_W-1:0]      wr_col;
    logic [DATA_WIDTH-1:0] wr_data;

    logic [DATA_WIDTH-1:0]          dout_q;
    logic                           dout_valid_q;
    logic [NUM_TAPS*DATA_WIDTH-1:0] taps_q;

    logic is_cr, is_lf, is_bs, at_last_row, at_last_col, rd_in_range;

    assign is_cr       = (bus.din == CR_CODE);
    assign is_lf       = (bus.din == LF_CODE);
    assign is_bs       = (bus.din == BS_CODE);
    assign at_last_row = (cur_row_q == LAST_ROW);
    assign at_last_col = (cur_col_q == LAST_COL);
    assign rd_in_range = (int'(bus.r_row) < int'(ROWS)) && (int'(bus.r_col) < int'(COLS));

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        cur_row_d = cur_row_q;
        cur_col_d = cur_col_q;
        swp_row_d = swp_row_q;
        swp_col_d = swp_col_q;
        wr_en     = 1'b0;
        wr_row    = cur_row_q;
        wr_col    = cur_col_q;
        wr_data   = bus.din;

        if (bus.clear) begin
            state_d   = ST_CLEAR;
            cur_row_d = '0;
            cur_col_d = '0;
            swp_row_d = '0;
            swp_col_d = '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    wr_en   = 1'b1;
                    wr_row  = swp_row_q;
                    wr_col  = swp_col_q;
                    wr_data = FILL_CODE;
                    if (swp_col_q != LAST_COL) begin
                        swp_col_d = swp_col_q + COL_ONE;
                    end else begin
                        swp_col_d = '0;
                        if (swp_row_q != LAST_ROW) begin
                            swp_row_d = swp_row_q + ROW_ONE;
                        end else begin
                            swp_row_d = '0;
                            state_d   = ST_RUN;
                            cur_row_d = '0;
                            cur_col_d = '0;
                        end
                    end
                end
                ST_RUN, ST_FULL: begin
                    if (bus.we) begin
                        if (is_cr) begin
                            cur_col_d = '0;
                            state_d   = ST_RUN;
                        end else if (is_bs) begin
                            state_d = ST_RUN;
                            if (cur_col_q != '0) begin
                                cur_col_d = cur_col_q - COL_ONE;
                                wr_en     = 1'b1;
                                wr_col    = cur_col_q - COL_ONE;
                                wr_data   = FILL_CODE;
                            end
                        end else if (state_q == ST_RUN) begin
                            // Printable codes and LF only act in RUN; FULL drops them.
                            if (is_lf) begin
                                cur_col_d = '0;
                                if (!at_last_row)   cur_row_d = cur_row_q + ROW_ONE;
                                else if (WRAP_MODE) cur_row_d = '0;
                                else                state_d   = ST_FULL;
                            end else begin
                                wr_en = 1'b1;
                                if (!at_last_col) begin
                                    cur_col_d = cur_col_q + COL_ONE;
                                end else if (!at_last_row) begin
                                    cur_col_d = '0;
                                    cur_row_d = cur_row_q + ROW_ONE;
                                end else if (WRAP_MODE) begin
                                    cur_col_d = '0;
                                    cur_row_d = '0;
                                end else begin
                                    state_d = ST_FULL;
                                end
                            end
                        end
                    end
                end
                default: begin
                    state_d   = ST_CLEAR;
                    swp_row_d = '0;
                    swp_col_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            state_q   <= ST_CLEAR;
            cur_row_q <= '0;
            cur_col_q <= '0;
            swp_row_q <= '0;
            swp_col_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_row_q <= cur_row_d;
            cur_col_q <= cur_col_d;
            swp_row_q <= swp_row_d;
            swp_col_q <= swp_col_d;
        end
    end

    // NOTE: the array has no reset; the clear sweep that follows reset fills it instead.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_row][wr_col] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            taps_q       <= '0;
        end else begin
            dout_valid_q <= bus.re;
            if (bus.re) dout_q <= rd_in_range ? mem[bus.r_row][bus.r_col] : FILL_CODE;
            for (int k = 0; k < int'(NUM_TAPS); k++) begin
                taps_q[k*DATA_WIDTH +: DATA_WIDTH] <= mem[0][k];
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.taps       = taps_q;
    assign bus.cur_row    = cur_row_q;
    assign bus.cur_col    = cur_col_q;
    assign bus.busy       = (state_q == ST_CLEAR);
    assign bus.full       = (state_q == ST_FULL);
endmodule

// File: tb/tb_text_frame_ram.sv
// Bench for text_frame_ram: default wrap instance, a no-wrap instance and a 3-row instance,
// checked against a linear-position model of the frame buffer.
module tb_text_frame_ram;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] BS = 8'h08;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    text_frame_ram_if #(.DATA_WIDTH(8), .ROWS(4), .COLS(32), .NUM_TAPS(2)) if_a ();
    text_frame_ram_if #(.DATA_WIDTH(8), .ROWS(4), .COLS(32), .NUM_TAPS(2)) if_w ();
    text_frame_ram_if #(.DATA_WIDTH(8), .ROWS(3), .COLS(32), .NUM_TAPS(2)) if_s ();

    text_frame_ram #(.DATA_WIDTH(8), .ROWS(4), .COLS(32), .NUM_TAPS(2), .WRAP_MODE(1'b1))
        u_a (.clk(clk), .reset(reset), .bus(if_a));
    text_frame_ram #(.DATA_WIDTH(8), .ROWS(4), .COLS(32), .NUM_TAPS(2), .WRAP_MODE(1'b0))
        u_w (.clk(clk), .reset(reset), .bus(if_w));
    text_frame_ram #(.DATA_WIDTH(8), .ROWS(3), .COLS(32), .NUM_TAPS(2), .WRAP_MODE(1'b1))
        u_s (.clk(clk), .reset(reset), .bus(if_s));

    int n_checks = 0;
    int n_fail   = 0;

    // Model: cells as a linear array per instance, cursor as a linear position.
    logic [7:0] mm [3][128];
    int         mpos  [3];
    bit         mfull [3];

    function automatic int rows_of(input int id);
        return (id == 2) ? 3 : 4;
    endfunction

    function automatic void mdl_clear(input int id);
        for (int c = 0; c < 128; c++) mm[id][c] = 8'h00;
        mpos[id]  = 0;
        mfull[id] = 1'b0;
    endfunction

    function automatic void mdl_apply(input int id, input logic [7:0] code);
        int cells;
        cells = rows_of(id) * 32;
        if (code == CR) begin
            mpos[id]  = mpos[id] - (mpos[id] % 32);
            mfull[id] = 1'b0;
        end else if (code == BS) begin
            if (mpos[id] % 32 != 0) begin
                mpos[id] = mpos[id] - 1;
                mm[id][mpos[id]] = 8'h00;
            end
            mfull[id] = 1'b0;
        end else if (mfull[id]) begin
            // dropped
        end else if (code == LF) begin
            if (mpos[id] / 32 == rows_of(id) - 1) begin
                if (id != 1) mpos[id] = 0;
                else begin
                    mpos[id]  = mpos[id] - (mpos[id] % 32);
                    mfull[id] = 1'b1;
                end
            end else begin
                mpos[id] = (mpos[id] / 32 + 1) * 32;
            end
        end else begin
            mm[id][mpos[id]] = code;
            if (mpos[id] == cells - 1) begin
                if (id != 1) mpos[id] = 0;
                else         mfull[id] = 1'b1;
            end else begin
                mpos[id] = mpos[id] + 1;
            end
        end
    endfunction

    function automatic logic [7:0] rand_print();
        return 8'($urandom_range(8'h20, 8'h7E));
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int id, input logic clr, input logic w, input logic [7:0] d,
                         input logic r, input logic [1:0] rr, input logic [4:0] rc);
        case (id)
            0:       begin if_a.clear = clr; if_a.we = w; if_a.din = d; if_a.re = r; if_a.r_row = rr; if_a.r_col = rc; end
            1:       begin if_w.clear = clr; if_w.we = w; if_w.din = d; if_w.re = r; if_w.r_row = rr; if_w.r_col = rc; end
            default: begin if_s.clear = clr; if_s.we = w; if_s.din = d; if_s.re = r; if_s.r_row = rr; if_s.r_col = rc; end
        endcase
    endtask

    task automatic sample(input int id, output logic [7:0] dout, output logic dv,
                          output logic [15:0] taps, output logic [1:0] crow,
                          output logic [4:0] ccol, output logic busy, output logic full);
        case (id)
            0:       begin dout = if_a.dout; dv = if_a.dout_valid; taps = if_a.taps; crow = if_a.cur_row; ccol = if_a.cur_col; busy = if_a.busy; full = if_a.full; end
            1:       begin dout = if_w.dout; dv = if_w.dout_valid; taps = if_w.taps; crow = if_w.cur_row; ccol = if_w.cur_col; busy = if_w.busy; full = if_w.full; end
            default: begin dout = if_s.dout; dv = if_s.dout_valid; taps = if_s.taps; crow = if_s.cur_row; ccol = if_s.cur_col; busy = if_s.busy; full = if_s.full; end
        endcase
    endtask

    task automatic wr(input int id, input logic [7:0] code);
        drive(id, 1'b0, 1'b1, code, 1'b0, 2'd0, 5'd0);
        cyc();
        drive(id, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 5'd0);
        mdl_apply(id, code);
    endtask

    task automatic rd(input int id, input int r, input int c, output logic [7:0] d, output logic v);
        logic [15:0] tp; logic [1:0] cr; logic [4:0] cc; logic bz, fl;
        drive(id, 1'b0, 1'b0, 8'h00, 1'b1, 2'(r), 5'(c));
        cyc();
        drive(id, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 5'd0);
        sample(id, d, v, tp, cr, cc, bz, fl);
    endtask

    task automatic do_clear(input int id, output int cnt);
        logic [7:0] d; logic v; logic [15:0] tp; logic [1:0] cr; logic [4:0] cc; logic bz, fl;
        drive(id, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 5'd0);
        cyc();
        drive(id, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 5'd0);
        cnt = 0;
        sample(id, d, v, tp, cr, cc, bz, fl);
        while (bz === 1'b1 && cnt < 400) begin
            cnt++;
            cyc();
            sample(id, d, v, tp, cr, cc, bz, fl);
        end
        mdl_clear(id);
    endtask

    task automatic verify_mem(input int id, input string name);
        logic [7:0] d; logic v;
        for (int c = 0; c < rows_of(id) * 32; c++) begin
            rd(id, c / 32, c % 32, d, v);
            n_checks++;
            if (d !== mm[id][c] || v !== 1'b1) begin
                n_fail++;
                $display("FAIL %s cell(%0d,%0d): got %h/%b expected %h/1", name, c / 32, c % 32, d, v, mm[id][c]);
            end
        end
    endtask

    task automatic check_cursor(input int id, input string name);
        logic [7:0] d; logic v; logic [15:0] tp; logic [1:0] cr; logic [4:0] cc; logic bz, fl;
        sample(id, d, v, tp, cr, cc, bz, fl);
        n_checks++;
        if ({cr, cc, fl} !== {2'(mpos[id] / 32), 5'(mpos[id] % 32), mfull[id]}) begin
            n_fail++;
            $display("FAIL %s cursor/full: got (%0d,%0d) full=%b expected (%0d,%0d) full=%b",
                     name, cr, cc, fl, mpos[id] / 32, mpos[id] % 32, mfull[id]);
        end
    endtask

    task automatic test_reset();
        logic [7:0] d; logic v; logic [15:0] tp; logic [1:0] cr; logic [4:0] cc; logic bz, fl;
        int cnt [3];
        logic b [3];
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 5'd0);
        #12;
        sample(0, d, v, tp, cr, cc, bz, fl);
        n_checks++;
        if ({bz, v, tp, cr, cc, fl} !== {1'b1, 1'b0, 16'h0000, 2'd0, 5'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b dv=%b taps=%h cur=(%0d,%0d) full=%b expected 1 0 0000 (0,0) 0",
                     bz, v, tp, cr, cc, fl);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) cnt[i] = 0;
        for (int t = 0; t < 300; t++) begin
            b[0] = if_a.busy; b[1] = if_w.busy; b[2] = if_s.busy;
            for (int i = 0; i < 3; i++) if (b[i] === 1'b1) cnt[i]++;
            if (b[0] !== 1'b1 && b[1] !== 1'b1 && b[2] !== 1'b1) break;
            cyc();
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (cnt[i] != rows_of(i) * 32) begin
                n_fail++;
                $display("FAIL reset_sweep_len[%0d]: got %0d cycles expected %0d", i, cnt[i], rows_of(i) * 32);
            end
            mdl_clear(i);
        end
        check_cursor(0, "reset_done");
        verify_mem(0, "reset_cleared");
    endtask

    task automatic test_cr();
        logic [7:0] d; logic v; logic [15:0] tp; logic [1:0] cr; logic [4:0] cc; logic bz, fl;
        wr(0, 8'h41); wr(0, 8'h42); wr(0, CR); wr(0, 8'h43);
        cyc();
        sample(0, d, v, tp, cr, cc, bz, fl);
        n_checks++;
        if (tp !== 16'h4243) begin
            n_fail++;
            $display("FAIL cr_taps: got %h expected 4243", tp);
        end
        n_checks++;
        if ({cr, cc} !== {2'd0, 5'd1}) begin
            n_fail++;
            $display("FAIL cr_cursor: got (%0d,%0d) expected (0,1)", cr, cc);
        end
        rd(0, 0, 0, d, v);
        n_checks++;
        if (d !== 8'h43) begin n_fail++; $display("FAIL cr_mem00: got %h expected 43", d); end
        rd(0, 0, 1, d, v);
        n_checks++;
        if (d !== 8'h42) begin n_fail++; $display("FAIL cr_mem01: got %h expected 42", d); end
    endtask

    task automatic test_lf();
        logic [7:0] d; logic v; logic [15:0] tp; logic [1:0] cr; logic [4:0] cc; logic bz, fl;
        int cnt;
        do_clear(0, cnt);
        wr(0, 8'h58); wr(0, LF); wr(0, 8'h59);
        sample(0, d, v, tp, cr, cc, bz, fl);
        n_checks++;
        if ({cr, cc} !== {2'd1, 5'd1}) begin
            n_fail++;
            $display("FAIL lf_cursor: got (%0d,%0d) expected (1,1)", cr, cc);
        end
        rd(0, 0, 0, d, v);
        n_checks++;
        if (d !== 8'h58) begin n_fail++; $display("FAIL lf_mem00: got %h expected 58", d); end
        rd(0, 1, 0, d, v);
        n_checks++;
        if (d !== 8'h59) begin n_fail++; $display("FAIL lf_mem10: got %h expected 59", d); end
        rd(0, 0, 1, d, v);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL lf_not_stored: got %h expected 00", d); end
    endtask

    task automatic test_bs();
        logic [7:0] d; logic v;
        logic [7:0] b [5];
        int cnt;
        do_clear(0, cnt);
        wr(0, LF); wr(0, LF);
        for (int i = 0; i < 5; i++) begin b[i] = rand_print(); wr(0, b[i]); end
        check_cursor(0, "bs_setup");
        wr(0, BS);
        check_cursor(0, "bs_step");
        rd(0, 2, 4, d, v);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL bs_fill: got %h expected 00", d); end
        rd(0, 2, 3, d, v);
        n_checks++;
        if (d !== b[3]) begin n_fail++; $display("FAIL bs_neighbour: got %h expected %h", d, b[3]); end
        wr(0, CR); wr(0, BS);
        check_cursor(0, "bs_col0");
        rd(0, 2, 0, d, v);
        n_checks++;
        if (d !== b[0]) begin n_fail++; $display("FAIL bs_col0_mem: got %h expected %h", d, b[0]); end
    endtask

    task automatic test_full();
        logic [7:0] d; logic v; logic [15:0] tp; logic [1:0] cr; logic [4:0] cc; logic bz, fl;
        logic [7:0] last;
        last = 8'h00;
        for (int i = 0; i < 128; i++) begin
            last = rand_print();
            wr(1, last);
            if (i >= 126) begin
                sample(1, d, v, tp, cr, cc, bz, fl);
                n_checks++;
                if (fl !== (i == 127)) begin
                    n_fail++;
                    $display("FAIL full_flag byte %0d: got %b expected %b", i + 1, fl, (i == 127));
                end
            end
        end
        wr(1, 8'h5A);
        check_cursor(1, "full_drop_z");
        rd(1, 3, 31, d, v);
        n_checks++;
        if (d !== last) begin n_fail++; $display("FAIL full_last_cell: got %h expected %h", d, last); end
        verify_mem(1, "full_contents");
        wr(1, CR);
        sample(1, d, v, tp, cr, cc, bz, fl);
        n_checks++;
        if ({fl, cr, cc} !== {1'b0, 2'd3, 5'd0}) begin
            n_fail++;
            $display("FAIL full_cr_exit: got full=%b (%0d,%0d) expected full=0 (3,0)", fl, cr, cc);
        end
    endtask

    task automatic test_oob();
        logic [7:0] d; logic v;
        for (int i = 0; i < 96; i++) wr(2, rand_print());
        check_cursor(2, "oob_wrap");
        rd(2, 3, 31, d, v);
        n_checks++;
        if ({d, v} !== {8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL oob_read: got %h dv=%b expected 00 dv=1", d, v);
        end
        rd(2, 2, 31, d, v);
        n_checks++;
        if (d !== mm[2][95]) begin n_fail++; $display("FAIL oob_last_valid: got %h expected %h", d, mm[2][95]); end
    endtask

    task automatic test_rw_same();
        logic [7:0] d; logic v; logic [15:0] tp; logic [1:0] cr; logic [4:0] cc; logic bz, fl;
        int cnt;
        do_clear(0, cnt);
        drive(0, 1'b0, 1'b1, 8'h55, 1'b1, 2'd0, 5'd0);
        cyc();
        drive(0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 5'd0);
        mdl_apply(0, 8'h55);
        sample(0, d, v, tp, cr, cc, bz, fl);
        n_checks++;
        if ({d, v, tp[7:0]} !== {8'h00, 1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL rw_old_data: got dout=%h dv=%b tap0=%h expected 00 1 00", d, v, tp[7:0]);
        end
        cyc();
        sample(0, d, v, tp, cr, cc, bz, fl);
        n_checks++;
        if ({d, v, tp[7:0]} !== {8'h00, 1'b0, 8'h55}) begin
            n_fail++;
            $display("FAIL rw_hold: got dout=%h dv=%b tap0=%h expected 00 0 55", d, v, tp[7:0]);
        end
        rd(0, 0, 0, d, v);
        n_checks++;
        if (d !== 8'h55) begin n_fail++; $display("FAIL rw_new_data: got %h expected 55", d); end
    endtask

    task automatic test_random();
        logic [7:0] d; logic v; logic [15:0] tp; logic [1:0] cr; logic [4:0] cc; logic bz, fl;
        logic [7:0] code, exp_dout;
        logic [15:0] exp_taps;
        logic w, r;
        logic [1:0] rr;
        logic [4:0] rc;
        int sel, cnt;
        do_clear(0, cnt);
        exp_dout = 8'h00;
        for (int i = 0; i < 400; i++) begin
            sel  = $urandom_range(0, 99);
            code = (sel < 10) ? CR : (sel < 20) ? LF : (sel < 30) ? BS : rand_print();
            w    = ($urandom_range(0, 9) != 0);
            r    = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            rr   = 2'($urandom_range(0, 3));
            rc   = 5'($urandom_range(0, 31));
            exp_taps = {mm[0][1], mm[0][0]};
            if (r) exp_dout = mm[0][int'(rr) * 32 + int'(rc)];
            drive(0, 1'b0, w, code, r, rr, rc);
            cyc();
            if (w) mdl_apply(0, code);
            sample(0, d, v, tp, cr, cc, bz, fl);
            n_checks++;
            if ({d, v, tp} !== {exp_dout, r, exp_taps}) begin
                n_fail++;
                $display("FAIL rand_read op %0d: got dout=%h dv=%b taps=%h expected %h %b %h",
                         i, d, v, tp, exp_dout, r, exp_taps);
            end
            check_cursor(0, "rand_cursor");
        end
        drive(0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 5'd0);
        verify_mem(0, "rand_contents");
    endtask

    task automatic test_clear_we();
        logic [7:0] d; logic v;
        int cnt;
        for (int i = 0; i < 7; i++) wr(0, rand_print());
        drive(0, 1'b1, 1'b1, 8'h51, 1'b0, 2'd0, 5'd0);
        cyc();
        drive(0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 5'd0);
        cnt = 0;
        while (if_a.busy === 1'b1 && cnt < 400) begin cnt++; cyc(); end
        mdl_clear(0);
        n_checks++;
        if (cnt != 128) begin n_fail++; $display("FAIL clear_we_sweep_len: got %0d expected 128", cnt); end
        check_cursor(0, "clear_we_cursor");
        rd(0, 0, 7, d, v);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL clear_we_dropped: got %h expected 00", d); end
    endtask

    task automatic test_reset_mid_sweep();
        logic [7:0] d; logic v;
        int cnt;
        drive(0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 5'd0);
        cyc();
        drive(0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 5'd0);
        repeat (40) cyc();
        reset = 1'b0;
        cyc(); cyc();
        n_checks++;
        if ({if_a.busy, if_a.cur_row, if_a.cur_col} !== {1'b1, 2'd0, 5'd0}) begin
            n_fail++;
            $display("FAIL mid_reset_state: got busy=%b (%0d,%0d) expected 1 (0,0)",
                     if_a.busy, if_a.cur_row, if_a.cur_col);
        end
        reset = 1'b1;
        cnt = 0;
        while (if_a.busy === 1'b1 && cnt < 400) begin cnt++; cyc(); end
        for (int i = 0; i < 3; i++) mdl_clear(i);
        n_checks++;
        if (cnt != 128) begin n_fail++; $display("FAIL mid_reset_sweep_len: got %0d expected 128", cnt); end
        rd(0, 3, 31, d, v);
        n_checks++;
        if ({d, v} !== {8'h00, 1'b1}) begin n_fail++; $display("FAIL mid_reset_cell: got %h/%b expected 00/1", d, v); end
    endtask

    initial begin
        test_reset();
        test_cr();
        test_lf();
        test_bs();
        test_full();
        test_oob();
        test_rw_same();
        test_random();
        test_clear_we();
        test_reset_mid_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
